cpu_fetch_queue: RTL and testbench
==================================

# cpu_fetch_queue

Decoupling queue between the fetch stage and the decode stage. It accepts fetch packets (`fetch_data_t`) through a strobe-toggle handshake and buffers up to DEPTH of them. It re-emits them in order on the same strobe-toggle protocol toward decode. This lets fetch keep issuing while decode is stalled. Backpressure to fetch covers the one packet that is already in flight.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥ 2.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_flush  in  1  discard all buffered and in-flight packets.
- i_data  in  fetch_data_t  packet from fetch; a new packet is present when `i_data.strobe` differs from the last consumed strobe.
- o_busy  out  1  backpressure to fetch; fetch issues only when low.
- i_busy  in  1  backpressure from decode.
- o_data  out  fetch_data_t  packet to decode; a new packet is signalled by a toggle of `o_data.strobe`.
- o_level  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky; a packet arrived while the queue was full.

## Operation
Input detection:
- `in_valid = (i_data.strobe != in_strobe_r)`.
- `in_strobe_r` is set to `i_data.strobe` on every edge where a packet is consumed (pushed or bypassed) or flushed.

Output:
- Each cycle with `!i_busy` and a packet available, load `o_data` from that packet, with `o_data.strobe <= ~o_data.strobe`.
- Pop source: the FIFO head if `count > 0`, otherwise the input bypass.
- All non-strobe fields are copied unchanged.

Bypass:
- If `count == 0`, `in_valid`, and `!i_busy`, the input goes straight to `o_data` with no FIFO write.

Push:
- If `in_valid` and the packet is not bypassed, write it at `wr_ptr`, increment `wr_ptr`, and increment `count`.
- Simultaneous push and pop leaves `count` unchanged.

Pointers:
- `$clog2(DEPTH)` bits, natural wrap-around.
- `count` is a separate register, range 0..DEPTH.

Backpressure:
- `o_busy = (count + in_valid) >= DEPTH`, combinational from registers and `i_data.strobe` only.
- It never depends on `i_busy`, which keeps the decode-to-fetch combinational path out.
- This guarantees the packet fetch launches after sampling `o_busy = 0` always has a slot.

Overflow:
- `in_valid` with `count == DEPTH` and no pop means the packet is dropped and `o_overflow` is set until reset.
- This cannot occur with a conforming fetch stage.

Flush (i_flush):
- `count`, `rd_ptr`, and `wr_ptr` are cleared.
- `in_strobe_r <= i_data.strobe`, so an in-flight packet is discarded.
- `o_data` is held; no strobe toggle occurs that cycle.
- Flush has priority over push, pop, and bypass.

## Timing
Reset values:
- `o_data` = 0, including strobe 0.
- `in_strobe_r` = 0, matching fetch's reset packet.
- `count`, `rd_ptr`, `wr_ptr` = 0.
- `o_level` = 0, `o_overflow` = 0.
- `o_busy` = 0, provided `i_data.strobe` = 0.

Reset mid-operation drops all contents. Strobe state realigns to 0 on both sides, because fetch also resets its packet.

Latency:
- Empty queue with decode ready: packet visible at input in cycle N appears on `o_data` after edge N+1.
- Otherwise a packet leaves one edge after it reaches the head with `i_busy` low.

Throughput: one packet per cycle sustained in both directions.

`o_level` is the registered `count`.

## Structure
- `fetch_data_t` and `register_t` stay in the shared CPU types package; no new shared typedefs.
- Natural sub-module: `cpu_fetch_queue_mem`, a DEPTH × `$bits(fetch_data_t)` register array.
  - One synchronous write port.
  - One asynchronous read port at `rd_ptr`.
  - Lets the storage be swapped for distributed RAM.
- Control (pointers, count, strobe tracking, bypass, flush) lives in the top module.

## Test plan
- **Bypass:** empty queue, `i_busy` = 0, toggle input strobe with pc 0x100 → `o_data.pc` = 0x100 and output strobe toggled after 1 edge; `o_level` stays 0.
- **Fill:** `i_busy` = 1, issue pcs 0x0, 0x4, 0x8, 0xC honouring `o_busy` → `o_busy` high when `count + in_valid` reaches 4; `o_level` = 4. Release `i_busy` → outputs 0x0, 0x4, 0x8, 0xC on 4 consecutive edges, each with a strobe toggle.
- **Wrap-around:** stream 20 packets with `i_busy` toggling every 3 cycles → in-order delivery, no loss, no duplicate, `o_overflow` = 0.
- **Simultaneous push/pop at full−1:** `count` = 3, input packet plus pop in the same edge → `count` stays 3; order preserved.
- **Flush:** `count` = 2 plus one in-flight packet, assert `i_flush` → `o_level` = 0, no output toggle. The next new packet, pc 0x200, is the first one delivered.
- **Overflow / reset:** force input toggles while full → `o_overflow` = 1, queue unchanged. Assert `i_reset` mid-stream → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared CPU types used by the fetch/decode decoupling queue.
package cpu_fetch_queue_pkg;

    typedef logic [31:0] register_t;

    typedef struct packed {
        logic      strobe;
        register_t pc;
        register_t instr;
    } fetch_data_t;

    localparam int FETCH_W = $bits(fetch_data_t);

endpackage

// File: rtl/cpu_fetch_queue_mem.sv
// Packet storage: synchronous write, asynchronous read, so it maps onto distributed RAM.
module cpu_fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     i_clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; no reset so the array stays plain RAM.
    always_ff @(posedge i_clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch-to-decode decoupling queue on strobe-toggle handshakes, with empty-queue bypass.
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  fetch_data_t            i_data,
    output logic                   o_busy,
    input  logic                   i_busy,
    output fetch_data_t            o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW:0]   FULL_W = (CW+1)'(DEPTH);

    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          in_strobe_r;

    logic          in_valid, fifo_pop, bypass, push, drop;
    logic [CW-1:0] count_next;
    logic [FETCH_W-1:0] rd_bits;
    fetch_data_t   head, src;

    assign in_valid = (i_data.strobe != in_strobe_r);
    assign fifo_pop = !i_busy && (count != '0);
    assign bypass   = in_valid && (count == '0) && !i_busy;
    // A full queue still accepts a packet when the head leaves on the same edge.
    assign push     = in_valid && !bypass && ((count != FULL) || fifo_pop);
    assign drop     = in_valid && (count == FULL) && !fifo_pop;

    // Counts the in-flight packet so fetch always has a slot for what it already launched.
    assign o_busy   = ({1'b0, count} + {{CW{1'b0}}, in_valid}) >= FULL_W;
    assign o_level  = count;

    assign head = fetch_data_t'(rd_bits);
    assign src  = fifo_pop ? head : i_data;

    // Occupancy update from push/pop combination.
    always_comb begin
        count_next = count;
        case ({push, fifo_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    cpu_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_W)
    ) u_mem (
        .i_clock (i_clock),
        .wr_en   (push && !i_flush && !i_reset),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_bits)
    );

    // Control state: reset, then flush, then normal push/pop/bypass.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            in_strobe_r <= 1'b0;
            o_data      <= '0;
            o_overflow  <= 1'b0;
        end else if (i_flush) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            in_strobe_r <= i_data.strobe;
        end else begin
            // Every seen packet is consumed: pushed, bypassed, or dropped on overflow.
            if (in_valid) in_strobe_r <= i_data.strobe;
            if (push)     wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            if (drop) o_overflow <= 1'b1;
            if (fifo_pop || bypass) begin
                o_data        <= src;
                o_data.strobe <= ~o_data.strobe;
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Randomized bench for cpu_fetch_queue against a queue-based packet model.
module tb_cpu_fetch_queue;
    import cpu_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        i_clock = 1'b0;
    logic        i_reset, i_flush, i_busy, o_busy, o_overflow;
    fetch_data_t i_data, o_data;
    logic [2:0]  o_level;

    int vectors = 0;
    int errors  = 0;

    // Reference model: packets waiting for decode, last strobe seen, last delivery.
    fetch_data_t mq[$];
    logic        m_last;
    fetch_data_t m_out;
    logic        m_ovf;
    logic        exp_busy, obs_busy;
    logic [31:0] rcv[$];

    cpu_fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_flush    (i_flush),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .i_busy     (i_busy),
        .o_data     (o_data),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [2:0] m_level();
        return 3'(mq.size());
    endfunction

    function automatic logic can_issue();
        return mq.size() < DEPTH;
    endfunction

    // Drive one cycle of stimulus, advance the model, land 1 time unit after the edge.
    task automatic step(input bit issue, input logic [31:0] pc);
        fetch_data_t pkt;
        logic inflight;
        if (issue) begin
            i_data.strobe = ~i_data.strobe;
            i_data.pc     = pc;
            i_data.instr  = $urandom;
        end
        #1;
        inflight = (i_data.strobe != m_last);
        exp_busy = (mq.size() + int'(inflight)) >= DEPTH;
        obs_busy = o_busy;
        if (i_reset) begin
            mq.delete(); m_last = 1'b0; m_out = '0; m_ovf = 1'b0;
        end else if (i_flush) begin
            mq.delete(); m_last = i_data.strobe;
        end else begin
            m_last = i_data.strobe;
            if (!i_busy && (mq.size() > 0 || inflight)) begin
                if (mq.size() > 0) begin
                    pkt = mq.pop_front();
                    if (inflight) mq.push_back(i_data);
                end else begin
                    pkt = i_data;
                end
                pkt.strobe = ~m_out.strobe;
                m_out = pkt;
            end else if (inflight) begin
                if (mq.size() < DEPTH) mq.push_back(i_data);
                else m_ovf = 1'b1;
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_busy = 1'b0; i_data = '0;
        step(0, 0);
        step(0, 0);
        vectors++;
        if ({o_data, o_level, o_overflow, o_busy} !== {fetch_data_t'(0), 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: data=%h lvl=%0d ovf=%b busy=%b want all zero", o_data, o_level, o_overflow, o_busy);
        end
        i_reset = 1'b0;
        step(0, 0);
    endtask

    task automatic test_bypass();
        logic s0;
        i_busy = 1'b0;
        s0 = o_data.strobe;
        step(1, 32'h100);
        vectors++;
        if (o_data.pc !== 32'h100 || o_data.strobe !== ~s0 || o_level !== 3'd0 ||
            o_data !== m_out || obs_busy !== exp_busy) begin
            errors++;
            $display("FAIL bypass: pc=%h strobe=%b lvl=%0d busy=%b want pc=100 strobe=%b lvl=0 busy=%b",
                     o_data.pc, o_data.strobe, o_level, obs_busy, ~s0, exp_busy);
        end
    endtask

    task automatic test_fill();
        i_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(can_issue(), 32'(i * 4));
            vectors++;
            if ({o_data, o_level, o_overflow, obs_busy} !== {m_out, m_level(), m_ovf, exp_busy}) begin
                errors++;
                $display("FAIL fill[%0d]: data=%h lvl=%0d ovf=%b busy=%b want data=%h lvl=%0d ovf=%b busy=%b",
                         i, o_data, o_level, o_overflow, obs_busy, m_out, m_level(), m_ovf, exp_busy);
            end
        end
        vectors++;
        if (o_level !== 3'd4 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: lvl=%0d busy=%b want lvl=4 busy=1", o_level, o_busy);
        end
        i_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            vectors++;
            if (o_data.pc !== 32'(i * 4) || o_data !== m_out || o_level !== m_level()) begin
                errors++;
                $display("FAIL drain[%0d]: pc=%h lvl=%0d want pc=%h lvl=%0d", i, o_data.pc, o_level, i * 4, m_level());
            end
        end
    endtask

    task automatic test_simul();
        i_busy = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i * 4));
        i_busy = 1'b0;
        step(1, 32'h30C);
        vectors++;
        if (o_level !== 3'd3 || o_data.pc !== 32'h300 || o_data !== m_out) begin
            errors++;
            $display("FAIL simul: lvl=%0d pc=%h want lvl=3 pc=300", o_level, o_data.pc);
        end
        for (int i = 1; i < 4; i++) begin
            step(0, 0);
            vectors++;
            if (o_data.pc !== 32'h300 + 32'(i * 4) || o_level !== m_level()) begin
                errors++;
                $display("FAIL simul_drain[%0d]: pc=%h lvl=%0d want pc=%h lvl=%0d",
                         i, o_data.pc, o_level, 32'h300 + 32'(i * 4), m_level());
            end
        end
    endtask

    task automatic test_flush();
        fetch_data_t held;
        i_busy = 1'b1;
        step(1, 32'h400);
        step(1, 32'h404);
        held = o_data;
        i_flush = 1'b1;
        step(1, 32'h408);
        i_flush = 1'b0;
        vectors++;
        if (o_level !== 3'd0 || o_data !== held || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush: lvl=%0d data=%h busy=%b want lvl=0 data=%h busy=0", o_level, o_data, o_busy, held);
        end
        i_busy = 1'b0;
        step(0, 0);
        vectors++;
        if (o_data !== held) begin
            errors++;
            $display("FAIL flush_quiet: data=%h want %h", o_data, held);
        end
        step(1, 32'h200);
        vectors++;
        if (o_data.pc !== 32'h200 || o_data.strobe !== ~held.strobe || o_data !== m_out) begin
            errors++;
            $display("FAIL flush_next: pc=%h strobe=%b want pc=200 strobe=%b", o_data.pc, o_data.strobe, ~held.strobe);
        end
    endtask

    task automatic test_overflow();
        i_busy = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 32'h500 + 32'(i * 4));
        step(1, 32'hDEAD0);
        step(1, 32'hDEAD4);
        vectors++;
        if (o_overflow !== 1'b1 || o_level !== 3'd4) begin
            errors++;
            $display("FAIL overflow: ovf=%b lvl=%0d want ovf=1 lvl=4", o_overflow, o_level);
        end
        i_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            vectors++;
            if ({o_data, o_level, o_overflow} !== {m_out, m_level(), m_ovf}) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: data=%h lvl=%0d ovf=%b want data=%h lvl=%0d ovf=%b",
                         i, o_data, o_level, o_overflow, m_out, m_level(), m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_busy = 1'b1;
        step(1, 32'h600);
        step(1, 32'h604);
        i_reset = 1'b1; i_data = '0;
        step(0, 0);
        i_reset = 1'b0;
        vectors++;
        if ({o_data, o_level, o_overflow, o_busy} !== {fetch_data_t'(0), 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: data=%h lvl=%0d ovf=%b busy=%b want all zero", o_data, o_level, o_overflow, o_busy);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        logic s_prev;
        rcv.delete();
        while (rcv.size() < 20 && cyc < 400) begin
            i_busy = ((cyc / 3) % 2) == 1;
            s_prev = o_data.strobe;
            if (sent < 20 && can_issue()) begin
                step(1, 32'h1000 + 32'(sent * 4));
                sent++;
            end else begin
                step(0, 0);
            end
            if (o_data.strobe !== s_prev) rcv.push_back(o_data.pc);
            vectors++;
            if ({o_data, o_level, o_overflow, obs_busy} !== {m_out, m_level(), m_ovf, exp_busy}) begin
                errors++;
                $display("FAIL wrap[%0d]: data=%h lvl=%0d ovf=%b busy=%b want data=%h lvl=%0d ovf=%b busy=%b",
                         cyc, o_data, o_level, o_overflow, obs_busy, m_out, m_level(), m_ovf, exp_busy);
            end
            cyc++;
        end
        vectors++;
        if (rcv.size() != 20) begin
            errors++;
            $display("FAIL wrap_count: got %0d packets want 20", rcv.size());
        end
        for (int i = 0; i < rcv.size(); i++) begin
            vectors++;
            if (rcv[i] !== 32'h1000 + 32'(i * 4)) begin
                errors++;
                $display("FAIL wrap_order[%0d]: pc=%h want %h", i, rcv[i], 32'h1000 + 32'(i * 4));
            end
        end
        vectors++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf: ovf=%b want 0", o_overflow);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_busy  = ($urandom_range(0, 2) == 0);
            i_flush = ($urandom_range(0, 40) == 0);
            step(can_issue() && $urandom_range(0, 3) != 0, $urandom);
            i_flush = 1'b0;
            vectors++;
            if ({o_data, o_level, o_overflow, obs_busy} !== {m_out, m_level(), m_ovf, exp_busy}) begin
                errors++;
                $display("FAIL random[%0d]: data=%h lvl=%0d ovf=%b busy=%b want data=%h lvl=%0d ovf=%b busy=%b",
                         c, o_data, o_level, o_overflow, obs_busy, m_out, m_level(), m_ovf, exp_busy);
            end
        end
    endtask

    initial begin
        m_last = 1'b0; m_out = '0; m_ovf = 1'b0;
        @(posedge i_clock);
        #1;
        test_reset();
        test_bypass();
        test_fill();
        test_simul();
        test_flush();
        test_wrap();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
